// File: rtl/judgement_sprite_ctrl.sv
// Hit-feedback sprite sequencer (Perfect/Good/Miss).
// Arms on a judgement event and waits for the next frame boundary. It then
// shows the selected sprite for SHOW_FRAMES full frames. While showing, it
// generates ROM addresses from DrawX/DrawY and delivers a colour index that
// is aligned with the ROM's one-cycle read latency.
module judgement_sprite_ctrl #(
  parameter int unsigned SPRITE_W    = 157,
  parameter int unsigned SPRITE_H    = 136,
  parameter int unsigned POS_X       = 241,
  parameter int unsigned POS_Y       = 100,
  parameter int unsigned SHOW_FRAMES = 30,
  parameter logic [7:0]  TRANSPARENT = 8'h00
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_start,
  input  logic        hit_valid,
  input  logic [1:0]  hit_kind,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [18:0] read_address,
  output logic [1:0]  rom_sel,
  input  logic [7:0]  rom_data,
  output logic        pixel_on,
  output logic [7:0]  pixel_index,
  output logic        active
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SHOW    = 2'd2
  } state_t;

  localparam logic [10:0] X_LO      = 11'(POS_X);
  localparam logic [10:0] X_HI      = 11'(POS_X + SPRITE_W);
  localparam logic [10:0] Y_LO      = 11'(POS_Y);
  localparam logic [10:0] Y_HI      = 11'(POS_Y + SPRITE_H);
  localparam logic [9:0]  X_OFF     = 10'(POS_X);
  localparam logic [9:0]  Y_OFF     = 10'(POS_Y);
  localparam logic [18:0] ROW_W     = 19'(SPRITE_W);
  localparam logic [7:0]  LAST_FRAME = 8'(SHOW_FRAMES - 1);

  state_t      state_q;
  logic [7:0]  frame_cnt_q;
  logic [1:0]  pend_kind_q;
  logic [1:0]  show_kind_q;
  logic [1:0]  rom_sel_q;
  logic        active_q;

  logic        hit_ok;
  logic        in_box;
  logic [9:0]  dx;
  logic [9:0]  dy;
  logic [18:0] addr_d;
  logic [18:0] addr_q;
  logic        v1_d;
  logic        v1_q;
  logic        v2_q;

  // Reserved kind 3 never counts as a judgement.
  assign hit_ok = hit_valid && (hit_kind != 2'd3);

  // Sequencer: arm on a hit, show from the next frame boundary, and count the frames shown.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      pend_kind_q <= '0;
      show_kind_q <= '0;
      rom_sel_q   <= '0;
      active_q    <= 1'b0;
    end else if (hit_ok && frame_start) begin
      // A hit on the boundary itself starts a fresh full frame right away.
      state_q     <= SHOW;
      show_kind_q <= hit_kind;
      rom_sel_q   <= hit_kind;
      frame_cnt_q <= '0;
      active_q    <= 1'b1;
    end else if (hit_ok) begin
      // A hit mid-frame cancels any current display, so no partial frame is shown.
      state_q     <= PENDING;
      pend_kind_q <= hit_kind;
      active_q    <= 1'b0;
    end else if (frame_start) begin
      case (state_q)
        PENDING: begin
          state_q     <= SHOW;
          show_kind_q <= pend_kind_q;
          rom_sel_q   <= pend_kind_q;
          frame_cnt_q <= '0;
          active_q    <= 1'b1;
        end
        SHOW: begin
          if (frame_cnt_q == LAST_FRAME) begin
            state_q  <= IDLE;
            active_q <= 1'b0;
          end else begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Box test and linear ROM address for the current draw coordinate.
  always_comb begin
    in_box = ({1'b0, DrawX} >= X_LO) && ({1'b0, DrawX} < X_HI) &&
             ({1'b0, DrawY} >= Y_LO) && ({1'b0, DrawY} < Y_HI);
    dx     = DrawX - X_OFF;
    dy     = DrawY - Y_OFF;
    addr_d = '0;
    if (in_box) begin
      addr_d = 19'(dy) * ROW_W + 19'(dx);
    end
    v1_d = in_box && (state_q == SHOW);
  end

  // Two-stage valid pipeline that matches the ROM's registered read.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      addr_q <= '0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
    end else begin
      addr_q <= addr_d;
      v1_q   <= v1_d;
      v2_q   <= v1_q;
    end
  end

  assign read_address = addr_q;
  assign rom_sel      = rom_sel_q;
  assign active       = active_q;
  assign pixel_on     = v2_q && (rom_data != TRANSPARENT);
  assign pixel_index  = pixel_on ? rom_data : '0;

endmodule

// File: tb/tb_judgement_sprite_ctrl.sv
// Bench for judgement_sprite_ctrl: directed scenarios followed by random traffic.
// Every cycle is checked against a frame-level behavioural model.
module tb_judgement_sprite_ctrl;

  localparam int PX = 241;
  localparam int PY = 100;
  localparam int SW = 157;
  localparam int SH = 136;
  localparam int SF = 3;

  logic        Clk;
  logic        Reset;
  logic        frame_start;
  logic        hit_valid;
  logic [1:0]  hit_kind;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [18:0] read_address;
  logic [1:0]  rom_sel;
  logic [7:0]  rom_data;
  logic        pixel_on;
  logic [7:0]  pixel_index;
  logic        active;

  judgement_sprite_ctrl #(
    .SPRITE_W(SW), .SPRITE_H(SH), .POS_X(PX), .POS_Y(PY),
    .SHOW_FRAMES(SF), .TRANSPARENT(8'h00)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
    .hit_valid(hit_valid), .hit_kind(hit_kind),
    .DrawX(DrawX), .DrawY(DrawY),
    .read_address(read_address), .rom_sel(rom_sel), .rom_data(rom_data),
    .pixel_on(pixel_on), .pixel_index(pixel_index), .active(active)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: mode 0 = nothing pending, 1 = waiting for a frame, 2 = visible.
  bit m_known = 0;
  int m_mode, m_pend, m_show, m_left;
  int m_addr;
  bit m_v1, m_v2;

  // Outputs observed in the most recent step.
  int obs_active, obs_sel, obs_addr, obs_pon, obs_pidx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit inbox(input int x, input int y);
    return x >= PX && x < PX + SW && y >= PY && y < PY + SH;
  endfunction

  // Drive one cycle of inputs, check the outputs mid-cycle, then advance the model at the edge.
  task automatic step(input bit rst, input bit fs, input bit hv, input bit [1:0] hk,
                      input int x, input int y, input bit [7:0] rd);
    bit exp_on;
    bit ok_hit;
    Reset = rst; frame_start = fs; hit_valid = hv; hit_kind = hk;
    DrawX = 10'(x); DrawY = 10'(y); rom_data = rd;
    #1;
    obs_active = int'(active);
    obs_sel    = int'(rom_sel);
    obs_addr   = int'(read_address);
    obs_pon    = int'(pixel_on);
    obs_pidx   = int'(pixel_index);
    if (m_known) begin
      exp_on = m_v2 && (rd != 8'h00);
      chk("active", 32'(active), 32'(m_mode == 2));
      chk("rom_sel", 32'(rom_sel), 32'(m_show));
      chk("read_address", 32'(read_address), 32'(m_addr));
      chk("pixel_on", 32'(pixel_on), 32'(exp_on));
      chk("pixel_index", 32'(pixel_index), exp_on ? 32'(rd) : 32'd0);
    end
    @(posedge Clk);
    if (rst) begin
      m_known = 1; m_mode = 0; m_pend = 0; m_show = 0; m_left = 0;
      m_addr = 0; m_v1 = 0; m_v2 = 0;
    end else begin
      m_v2   = m_v1;
      m_v1   = inbox(x, y) && (m_mode == 2);
      m_addr = inbox(x, y) ? (y - PY) * SW + (x - PX) : 0;
      ok_hit = hv && (hk != 2'd3);
      if (ok_hit && fs) begin
        m_mode = 2; m_show = int'(hk); m_left = SF;
      end else if (ok_hit) begin
        m_mode = 1; m_pend = int'(hk);
      end else if (fs) begin
        if (m_mode == 1) begin
          m_mode = 2; m_show = m_pend; m_left = SF;
        end else if (m_mode == 2) begin
          m_left = m_left - 1;
          if (m_left == 0) m_mode = 0;
        end
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 2'd0, 0, 0, 8'h00);
  endtask

  initial begin
    Reset = 1'b1; frame_start = 1'b0; hit_valid = 1'b0; hit_kind = 2'd0;
    DrawX = '0; DrawY = '0; rom_data = '0;

    // Reset state.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 2'd0, 0, 0, 8'h00);
    idle(1);
    chk("rst_active", 32'(obs_active), 32'd0);
    chk("rst_sel", 32'(obs_sel), 32'd0);
    chk("rst_addr", 32'(obs_addr), 32'd0);

    // Kind 1 armed, shown from the frame_start five cycles later.
    step(0, 0, 1, 2'd1, 0, 0, 8'h00);
    idle(4);
    step(0, 1, 0, 2'd0, 0, 0, 8'h00);
    step(0, 0, 0, 2'd0, 241, 100, 8'h00);
    chk("entry_active", 32'(obs_active), 32'd1);
    chk("entry_sel", 32'(obs_sel), 32'd1);
    step(0, 0, 0, 2'd0, 397, 235, 8'h00);
    chk("addr_origin", 32'(obs_addr), 32'd0);
    step(0, 0, 0, 2'd0, 398, 235, 8'h2A);
    chk("origin_on", 32'(obs_pon), 32'd1);
    chk("origin_idx", 32'(obs_pidx), 32'h2A);
    chk("addr_last", 32'(obs_addr), 32'd21351);
    step(0, 0, 0, 2'd0, 300, 99, 8'h00);
    chk("transp_on", 32'(obs_pon), 32'd0);
    chk("addr_x_out", 32'(obs_addr), 32'd0);
    step(0, 0, 0, 2'd0, 300, 150, 8'h55);
    chk("xout_on", 32'(obs_pon), 32'd0);
    chk("addr_y_out", 32'(obs_addr), 32'd0);
    step(0, 0, 0, 2'd0, 0, 0, 8'h55);
    chk("yout_on", 32'(obs_pon), 32'd0);
    chk("addr_mid", 32'(obs_addr), 32'd7909);

    // Exactly SF frames: active falls on the third subsequent frame_start.
    step(0, 1, 0, 2'd0, 0, 0, 8'h00);
    idle(1);
    chk("frame1_active", 32'(obs_active), 32'd1);
    step(0, 1, 0, 2'd0, 0, 0, 8'h00);
    idle(1);
    chk("frame2_active", 32'(obs_active), 32'd1);
    step(0, 1, 0, 2'd0, 300, 150, 8'h00);
    step(0, 0, 0, 2'd0, 300, 150, 8'h77);
    chk("expired_active", 32'(obs_active), 32'd0);
    step(0, 0, 0, 2'd0, 0, 0, 8'h77);
    step(0, 0, 0, 2'd0, 0, 0, 8'h77);
    chk("expired_pixel", 32'(obs_pon), 32'd0);

    // Retriggers.
    step(0, 1, 1, 2'd1, 0, 0, 8'h00);
    step(0, 0, 1, 2'd2, 0, 0, 8'h00);
    chk("rt_active", 32'(obs_active), 32'd1);
    idle(1);
    chk("rt_pend_active", 32'(obs_active), 32'd0);
    chk("rt_pend_sel", 32'(obs_sel), 32'd1);
    idle(3);
    chk("rt_hold_sel", 32'(obs_sel), 32'd1);
    step(0, 1, 0, 2'd0, 0, 0, 8'h00);
    step(0, 1, 1, 2'd0, 0, 0, 8'h00);
    chk("rt_show_sel", 32'(obs_sel), 32'd2);
    chk("rt_show_active", 32'(obs_active), 32'd1);
    step(0, 1, 0, 2'd0, 0, 0, 8'h00);
    chk("rt_now_sel", 32'(obs_sel), 32'd0);
    chk("rt_now_active", 32'(obs_active), 32'd1);
    step(0, 1, 0, 2'd0, 0, 0, 8'h00);
    step(0, 1, 0, 2'd0, 0, 0, 8'h00);
    chk("rt_cnt_restart", 32'(obs_active), 32'd1);
    idle(1);
    chk("rt_cnt_done", 32'(obs_active), 32'd0);

    // Reserved kind 3 in every state.
    step(0, 0, 1, 2'd3, 0, 0, 8'h00);
    step(0, 1, 0, 2'd0, 0, 0, 8'h00);
    idle(1);
    chk("k3_idle", 32'(obs_active), 32'd0);
    step(0, 0, 1, 2'd1, 0, 0, 8'h00);
    step(0, 0, 1, 2'd3, 0, 0, 8'h00);
    step(0, 1, 0, 2'd0, 0, 0, 8'h00);
    idle(1);
    chk("k3_pend_sel", 32'(obs_sel), 32'd1);
    chk("k3_pend_active", 32'(obs_active), 32'd1);
    step(0, 0, 1, 2'd3, 0, 0, 8'h00);
    idle(1);
    chk("k3_show_active", 32'(obs_active), 32'd1);

    // Reset held 3 cycles mid-SHOW with DrawX at the box edge.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 2'd0, PX, PY, 8'h5A);
    step(0, 1, 0, 2'd0, PX, PY, 8'h5A);
    chk("mrst_active", 32'(obs_active), 32'd0);
    chk("mrst_sel", 32'(obs_sel), 32'd0);
    chk("mrst_pon", 32'(obs_pon), 32'd0);
    chk("mrst_idx", 32'(obs_pidx), 32'd0);
    idle(1);
    chk("mrst_no_show", 32'(obs_active), 32'd0);

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      bit rst, fs, hv;
      bit [1:0] hk;
      int x, y;
      bit [7:0] rd;
      rst = ($urandom % 500) == 0;
      fs  = ($urandom % 30) == 0;
      hv  = ($urandom % 15) == 0;
      hk  = 2'($urandom % 4);
      x   = (($urandom % 8) == 0) ? int'($urandom % 1024) : 230 + int'($urandom % 185);
      y   = (($urandom % 8) == 0) ? int'($urandom % 1024) : 90 + int'($urandom % 160);
      rd  = (($urandom % 4) == 0) ? 8'h00 : 8'($urandom);
      step(rst, fs, hv, hk, x, y, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/judgement_sprite_ctrl.md
Name: judgement_sprite_ctrl

Overview:
- Sequences the hit-feedback sprite ROMs (Perfect/Good/Miss) for the VGA draw path.
- On a judgement event it arms, waits for the next frame boundary, then shows the selected sprite for a fixed number of frames.
- During display it generates ROM read addresses from DrawX/DrawY and selects which sprite ROM drives rom_data.
- Compensates the ROM's 1-cycle read latency and emits an aligned pixel enable and colour index to the colour mapper.

Parameters:
- SPRITE_W, 157, sprite width in pixels.
- SPRITE_H, 136, sprite height in pixels (W*H = 21352 ROM words).
- POS_X, 241, screen X of the sprite's top-left pixel.
- POS_Y, 100, screen Y of the sprite's top-left pixel.
- SHOW_FRAMES, 30, number of frames a sprite stays visible (1..255).
- TRANSPARENT, 8'h00, ROM colour index treated as see-through.

Ports:
- Clk  in  1  system clock; all logic is on posedge Clk.
- Reset  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse at the start of each frame (vsync edge).
- hit_valid  in  1  one-cycle judgement event.
- hit_kind  in  2  0=Perfect, 1=Good, 2=Miss, 3=reserved.
- DrawX  in  10  current pixel X.
- DrawY  in  10  current pixel Y.
- read_address  out  19  registered ROM address, shared by all sprite ROMs.
- rom_sel  out  2  registered selector for the rom_data mux (shown kind).
- rom_data  in  8  colour index returned by the selected ROM, 1 cycle after its address.
- pixel_on  out  1  sprite pixel is opaque at the 2-cycle-delayed DrawX/DrawY.
- pixel_index  out  8  colour index for that pixel; 0 when pixel_on=0.
- active  out  1  high while the state is SHOW.

Behaviour:
- Clock is Clk. Reset is synchronous and active-high.
- Reset, including mid-operation, forces:
  - state IDLE; frame_cnt=0; pend_kind=0; show_kind=0;
  - read_address=0; rom_sel=0; both pipeline valid flags 0;
  - pixel_on=0; pixel_index=0; active=0.
- hit_valid with hit_kind=3 is ignored in every state.
- Valid hit means hit_valid=1 and hit_kind!=3.
- FSM states: IDLE, PENDING, SHOW.
  - Valid hit without frame_start (any state): pend_kind<=hit_kind; next state PENDING.
    - SHOW ends immediately. active drops the next cycle.
  - Valid hit together with frame_start (any state): show_kind<=hit_kind; frame_cnt<=0; next state SHOW.
  - PENDING with frame_start and no hit: show_kind<=pend_kind; frame_cnt<=0; next state SHOW.
  - SHOW with frame_start and no hit:
    - if frame_cnt==SHOW_FRAMES-1, go to IDLE;
    - otherwise frame_cnt<=frame_cnt+1.
  - Net effect: the sprite is visible for exactly SHOW_FRAMES full frames.
  - A retrigger restarts the count and never shows a partial frame.
- active is registered and equals (state==SHOW).
- rom_sel is registered and equals show_kind. It changes only on entry to SHOW.
- Stage 1 (register, 1 cycle after DrawX/DrawY):
  - in_box = (POS_X <= DrawX < POS_X+SPRITE_W) && (POS_Y <= DrawY < POS_Y+SPRITE_H).
  - v1 <= in_box && state==SHOW.
  - read_address <= in_box ? (DrawY-POS_Y)*SPRITE_W + (DrawX-POS_X) : 0.
  - Computed at 19-bit width, zero-extended. Maximum value is 21351.
  - A multiplier or a running row-base accumulator is acceptable. Results must be identical.
- Stage 2 (register): v2 <= v1.
  - rom_data is valid in this same cycle, since the ROM registers read_address.
- Output (combinational from stage 2):
  - pixel_on = v2 && (rom_data != TRANSPARENT).
  - pixel_index = pixel_on ? rom_data : 0.
- Total latency DrawX/DrawY -> pixel_on/pixel_index is 2 Clk cycles. The draw path delays its own coordinates to match.
- SHOW ends mid-frame only via a retrigger. In-flight v1/v2 stay valid for their 2-cycle drain.
- Pixels outside the box never assert pixel_on, regardless of rom_data.

Test Plan:
- Reset held 3 cycles mid-SHOW with DrawX=POS_X -> next cycle all outputs 0 and state IDLE; the following frame_start does not enter SHOW.
- hit_valid, kind=1, then frame_start 5 cycles later -> active=1 the cycle after frame_start, rom_sel=1; DrawX=241, DrawY=100 gives read_address=0 one cycle later; ROM returns 8'h2A -> pixel_on=1, pixel_index=8'h2A two cycles after the coordinates.
- DrawX=397, DrawY=235 during SHOW -> read_address=21351.
- DrawX=398 or DrawY=99 -> read_address=0 and pixel_on=0.
- rom_data=8'h00 inside the box -> pixel_on=0, pixel_index=0.
- SHOW_FRAMES=3: count frame_starts after entry -> active falls exactly on the 3rd subsequent frame_start; no pixel_on afterwards.
- Retrigger during SHOW:
  - hit kind=2 (no frame_start) -> state PENDING, active=0, and rom_sel keeps the old kind until the next frame_start, then becomes 2.
  - hit kind=0 coincident with frame_start -> state SHOW immediately, rom_sel=0, frame_cnt=0.
- hit_kind=3 pulses in all states -> no state change.
